// File: rtl/vga_pixel_out_pkg.sv
// Shared video definitions: palette constants, fade FSM encoding and the
// per-pixel control bundle that travels alongside the palette ROM read.
package vga_pixel_out_pkg;

    localparam logic [11:0] KEY_COLOR = 12'hF0F;
    localparam logic [11:0] BG_COLOR  = 12'h000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } fade_state_e;

    typedef struct packed {
        logic valid;
        logic notBlank;
        logic isDark;
        logic hs;
        logic vs;
    } pix_ctrl_t;

    // Right-shifts each 4-bit channel; four or more steps of dimming is black.
    function automatic logic [11:0] dimColor(input logic [11:0] color,
                                             input logic [3:0]  shift);
        logic [11:0] result;
        result = 12'h000;
        if (shift < 4'd4) begin
            result = {color[11:8] >> shift[1:0],
                      color[7:4]  >> shift[1:0],
                      color[3:0]  >> shift[1:0]};
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_pixel_out_delay.sv
// Fixed-depth shift register with an asynchronously loaded reset value,
// used to carry pixel control bits across the palette ROM latency.
module pixel_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_value_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= rst_value_i;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_out.sv
// Video output stage: palette ROM addressing, colour-key transparency,
// dark-room dimming, frame-based fade sequencing and registered VGA pins.
module vga_pixel_out
    import vga_pixel_out_pkg::*;
#(
    parameter int ROM_LAT         = 1,
    parameter int FRAMES_PER_STEP = 4,
    parameter int MAX_LEVEL       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] pixel_addr,
    input  logic        notBlank,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        isDark,
    input  logic        fade_req,
    output logic [16:0] mem_addr,
    input  logic [11:0] mem_data,
    output logic [3:0]  vgaRed,
    output logic [3:0]  vgaGreen,
    output logic [3:0]  vgaBlue,
    output logic        hsync,
    output logic        vsync,
    output logic        fade_busy,
    output logic        fade_mid,
    output logic        fade_done
);

    localparam logic [7:0] FCNT_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [2:0] LEVEL_MAX = 3'(MAX_LEVEL);

    logic [16:0] mem_addr_q;
    pix_ctrl_t   ctrl_in;
    pix_ctrl_t   ctrl_dly;
    pix_ctrl_t   ctrl_rst;

    fade_state_e state_q, state_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [2:0]  level_q, level_d;
    logic        mid_q, mid_d;
    logic        done_q, done_d;
    logic        vsync_prev_q;
    logic        boundary;
    logic        step_end;

    logic [11:0] base_color;
    logic [3:0]  shift_amt;
    logic [11:0] rgb_d, rgb_q;
    logic        hsync_q, vsync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr_q <= '0;
        end else begin
            mem_addr_q <= pixel_addr;
        end
    end

    assign ctrl_in  = {valid, notBlank, isDark, hsync_in, vsync_in};
    assign ctrl_rst = '{valid: 1'b0, notBlank: 1'b0, isDark: 1'b0, hs: 1'b1, vs: 1'b1};

    // One extra stage beyond the ROM latency covers the stage-A address register.
    pixel_delay_line #(
        .WIDTH($bits(pix_ctrl_t)),
        .DEPTH(ROM_LAT + 1)
    ) u_ctrl_delay (
        .clk        (clk),
        .rst        (rst),
        .rst_value_i(ctrl_rst),
        .d_i        (ctrl_in),
        .q_o        (ctrl_dly)
    );

    // Frame boundaries come from the raw vsync so fade timing ignores ROM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_q <= 1'b1;
        end else begin
            vsync_prev_q <= vsync_in;
        end
    end

    assign boundary = vsync_prev_q & ~vsync_in;
    assign step_end = boundary && (fcnt_q == FCNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
            level_q <= '0;
            mid_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            level_q <= level_d;
            mid_q   <= mid_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        level_d = level_q;
        mid_d   = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fade_req) begin
                    state_d = FADE_OUT;
                    fcnt_d  = '0;
                    level_d = '0;
                end
            end
            FADE_OUT: begin
                if (step_end) begin
                    fcnt_d = '0;
                    if (level_q == LEVEL_MAX) begin
                        state_d = FADE_IN;
                        mid_d   = 1'b1;
                    end else begin
                        level_d = level_q + 3'd1;
                    end
                end else if (boundary) begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
            FADE_IN: begin
                if (step_end) begin
                    fcnt_d = '0;
                    if (level_q == 3'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        level_d = level_q - 3'd1;
                    end
                end else if (boundary) begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
                level_d = '0;
            end
        endcase
    end

    always_comb begin
        base_color = mem_data;
        if (!ctrl_dly.valid) begin
            base_color = 12'h000;
        end else if (!ctrl_dly.notBlank) begin
            base_color = BG_COLOR;
        end else if (mem_data == KEY_COLOR) begin
            base_color = BG_COLOR;
        end
        shift_amt = {1'b0, level_q} + {3'b000, ctrl_dly.isDark};
        rgb_d     = dimColor(base_color, shift_amt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q   <= 12'h000;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= ctrl_dly.hs;
            vsync_q <= ctrl_dly.vs;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign vgaRed    = rgb_q[11:8];
    assign vgaGreen  = rgb_q[7:4];
    assign vgaBlue   = rgb_q[3:0];
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign fade_busy = (state_q != IDLE);
    assign fade_mid  = mid_q;
    assign fade_done = done_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// Directed bench for vga_pixel_out: pipelined colour vectors, fade sequencing
// with a one-frame step, an ignored mid-fade request and an async reset mid-fade.
module tb_vga_pixel_out;

   typedef struct {
      logic [16:0] addr;
      logic        nb;
      logic        v;
      logic        dk;
      logic        hs;
      logic        vs;
      logic [11:0] expRgb;
      logic        expHs;
      logic        expVs;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [16:0] pixelAddr;
   logic        notBlankIn;
   logic        validIn;
   logic        hsyncIn;
   logic        vsyncIn;
   logic        isDarkIn;
   logic        fadeReq;
   logic [16:0] memAddr;
   logic [11:0] memData = 12'h000;
   logic [3:0]  red, green, blue;
   logic        hsyncOut, vsyncOut;
   logic        fadeBusy, fadeMid, fadeDone;
   logic [11:0] rgbOut;

   int checks = 0;
   int errors = 0;
   int midCount = 0;
   int doneCount = 0;

   vec_t vecs[12];

   vga_pixel_out #(
      .ROM_LAT(1),
      .FRAMES_PER_STEP(1),
      .MAX_LEVEL(4)
   ) dut (
      .clk(clock),
      .rst(reset),
      .pixel_addr(pixelAddr),
      .notBlank(notBlankIn),
      .valid(validIn),
      .hsync_in(hsyncIn),
      .vsync_in(vsyncIn),
      .isDark(isDarkIn),
      .fade_req(fadeReq),
      .mem_addr(memAddr),
      .mem_data(memData),
      .vgaRed(red),
      .vgaGreen(green),
      .vgaBlue(blue),
      .hsync(hsyncOut),
      .vsync(vsyncOut),
      .fade_busy(fadeBusy),
      .fade_mid(fadeMid),
      .fade_done(fadeDone)
   );

   assign rgbOut = {red, green, blue};

   always #5 clock = ~clock;

   // Palette ROM model with one cycle of read latency; one special entry,
   // everything else returns the low twelve address bits.
   function automatic logic [11:0] romModel(input logic [16:0] a);
      if (a == 17'h00123) return 12'hA5C;
      return a[11:0];
   endfunction

   always @(posedge clock) begin
      memData <= romModel(memAddr);
   end

   // Pulse counters catch any fade_mid/fade_done activity between explicit checks.
   always @(negedge clock) begin
      if (fadeMid === 1'b1) midCount++;
      if (fadeDone === 1'b1) doneCount++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic applyStimulus(input vec_t v);
      pixelAddr  = v.addr;
      notBlankIn = v.nb;
      validIn    = v.v;
      isDarkIn   = v.dk;
      hsyncIn    = v.hs;
      vsyncIn    = v.vs;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Solid white drawn pixel, so the output shows the fade level directly.
   task automatic holdWhite();
      vec_t w;
      w = '{17'h00FFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFFF, 1'b1, 1'b1};
      applyStimulus(w);
   endtask

   // Drives one vsync falling edge; returns on the negedge after it was sampled.
   task automatic frameBoundary(input bit withReq);
      repeat (3) @(negedge clock);
      vsyncIn = 1'b0;
      if (withReq) fadeReq = 1'b1;
      @(negedge clock);
      vsyncIn = 1'b1;
      fadeReq = 1'b0;
   endtask

   // Full fade with one frame per step; optionally re-requests at boundary 3.
   task automatic runFade(input string tag, input bit extraReq);
      logic [11:0] expRgb [10];
      int midBase;
      int doneBase;
      expRgb = '{12'h777, 12'h333, 12'h111, 12'h000, 12'h000,
                 12'h111, 12'h333, 12'h777, 12'hFFF, 12'hFFF};
      holdWhite();
      repeat (4) @(negedge clock);
      midBase  = midCount;
      doneBase = doneCount;
      fadeReq = 1'b1;
      @(negedge clock);
      fadeReq = 1'b0;
      checkOutput({tag, "_busyStart"}, 16'(fadeBusy), 16'd1);
      for (int b = 1; b <= 10; b++) begin
         frameBoundary(extraReq && (b == 3));
         checkOutput($sformatf("%s_mid_b%0d", tag, b), 16'(fadeMid), 16'(b == 5));
         checkOutput($sformatf("%s_done_b%0d", tag, b), 16'(fadeDone), 16'(b == 10));
         checkOutput($sformatf("%s_busy_b%0d", tag, b), 16'(fadeBusy), 16'(b != 10));
         @(negedge clock);
         checkOutput($sformatf("%s_pulseEnd_b%0d", tag, b), 16'({fadeMid, fadeDone}), 16'd0);
         repeat (3) @(negedge clock);
         checkOutput($sformatf("%s_rgb_b%0d", tag, b), 16'(rgbOut), 16'(expRgb[b-1]));
      end
      checkOutput({tag, "_midCount"}, 16'(midCount - midBase), 16'd1);
      checkOutput({tag, "_doneCount"}, 16'(doneCount - doneBase), 16'd1);
   endtask

   initial begin
      vec_t idleVec;
      int midBase;
      int doneBase;

      idleVec = '{17'h00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
      applyStimulus(idleVec);
      fadeReq = 1'b0;

      //              addr       nb    v     dk    hs    vs    rgb      hs    vs
      vecs[0]  = '{17'h00123, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'hA5C, 1'b0, 1'b1};
      vecs[1]  = '{17'h00F0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
      vecs[2]  = '{17'h00777, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
      vecs[3]  = '{17'h00777, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1};
      vecs[4]  = '{17'h00FA4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h752, 1'b1, 1'b1};
      vecs[5]  = '{17'h00777, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12'h777, 1'b1, 1'b0};
      vecs[6]  = '{17'h00FFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h777, 1'b1, 1'b1};
      vecs[7]  = '{17'h000A5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h0A5, 1'b0, 1'b1};
      vecs[8]  = '{17'h00FA4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'hFA4, 1'b1, 1'b1};
      vecs[9]  = '{17'h00123, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h526, 1'b1, 1'b1};
      vecs[10] = '{17'h00F0E, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 12'hF0E, 1'b1, 1'b1};
      vecs[11] = '{17'h10F0F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0};

      // Power-on reset state.
      #1 reset = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("reset_rgb", 16'(rgbOut), 16'h000);
      checkOutput("reset_sync", 16'({hsyncOut, vsyncOut}), 16'd3);
      checkOutput("reset_memAddr", 16'(memAddr[15:0]), 16'h0000);
      checkOutput("reset_flags", 16'({fadeBusy, fadeMid, fadeDone}), 16'd0);
      reset = 1'b0;
      repeat (2) @(negedge clock);

      // Back-to-back vectors; each result must appear exactly three cycles later.
      for (int i = 0; i < 15; i++) begin
         if (i >= 3) begin
            checkOutput($sformatf("vec%0d", i - 3), 16'({rgbOut, hsyncOut, vsyncOut}),
                        16'({vecs[i-3].expRgb, vecs[i-3].expHs, vecs[i-3].expVs}));
         end
         if (i < 12) applyStimulus(vecs[i]);
         else applyStimulus(idleVec);
         @(negedge clock);
      end

      runFade("fadeA", 1'b0);
      runFade("fadeB", 1'b1);

      // Async reset asserted between edges while the fade sits at level 2.
      holdWhite();
      repeat (4) @(negedge clock);
      fadeReq = 1'b1;
      @(negedge clock);
      fadeReq = 1'b0;
      frameBoundary(1'b0);
      frameBoundary(1'b0);
      hsyncIn = 1'b0;
      repeat (5) @(negedge clock);
      checkOutput("preReset_rgb", 16'(rgbOut), 16'h333);
      checkOutput("preReset_hsync", 16'(hsyncOut), 16'd0);
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncReset_rgb", 16'(rgbOut), 16'h000);
      checkOutput("asyncReset_sync", 16'({hsyncOut, vsyncOut}), 16'd3);
      checkOutput("asyncReset_busy", 16'(fadeBusy), 16'd0);
      checkOutput("asyncReset_pulses", 16'({fadeMid, fadeDone}), 16'd0);
      checkOutput("asyncReset_memAddr", 16'(memAddr[15:0]), 16'h0000);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      hsyncIn = 1'b1;
      midBase  = midCount;
      doneBase = doneCount;
      for (int b = 0; b < 10; b++) begin
         frameBoundary(1'b0);
      end
      repeat (4) @(negedge clock);
      checkOutput("postReset_midCount", 16'(midCount - midBase), 16'd0);
      checkOutput("postReset_doneCount", 16'(doneCount - doneBase), 16'd0);
      checkOutput("postReset_busy", 16'(fadeBusy), 16'd0);
      checkOutput("postReset_rgb", 16'(rgbOut), 16'hFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
